// File: rtl/div_result_bcd.sv
// ---------------------------------------------------------------------------
// div_result_bcd
//   Converts the unsigned quotient and remainder of a binary divider into
//   packed BCD. Both values go through shift-add-3 (double dabble) side by
//   side, so a conversion takes exactly SIZE cycles. A divider error skips
//   the conversion and publishes an all-zero result with err_out set on the
//   next cycle.
//
// Handshake: done is a one-cycle pulse. It is accepted only when the block
//   is idle (busy=0). A done that arrives while busy=1 is dropped and
//   reported by a one-cycle overrun pulse. valid stays high, and the result
//   outputs stay stable, until the next accepted done.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   done       divider result-ready pulse
//   error      divider error flag (qualified by done)
//   quotient   SIZE-bit unsigned quotient (qualified by done)
//   remainder  SIZE-bit unsigned remainder (qualified by done)
//   busy       conversion in progress
//   valid      q_bcd / r_bcd / err_out hold a completed result
//   err_out    captured divider error of the current result
//   overrun    one-cycle pulse when a done is dropped
//   q_bcd      packed BCD of quotient, most significant digit on top
//   r_bcd      packed BCD of remainder, same packing
// ---------------------------------------------------------------------------
module div_result_bcd #(
    parameter int SIZE   = 32,
    parameter int DIGITS = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  done,
    input  logic                  error,
    input  logic [SIZE-1:0]       quotient,
    input  logic [SIZE-1:0]       remainder,
    output logic                  busy,
    output logic                  valid,
    output logic                  err_out,
    output logic                  overrun,
    output logic [4*DIGITS-1:0]   q_bcd,
    output logic [4*DIGITS-1:0]   r_bcd
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(SIZE + 1);

    // ERRHOLD is part of the state set but is never entered: an error
    // result is published directly from IDLE in a single cycle.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        ERRHOLD = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;

    logic [SIZE-1:0] q_bin;
    logic [SIZE-1:0] r_bin;
    logic [BW-1:0]   q_acc;
    logic [BW-1:0]   r_acc;
    logic [BW-1:0]   q_adj;
    logic [BW-1:0]   r_adj;
    logic [BW-1:0]   q_acc_next;
    logic [BW-1:0]   r_acc_next;
    logic [CW-1:0]   cnt;
    logic            accept;
    logic            accept_err;
    logic            last_shift;

    // Add 3 to every nibble that is 5 or more, so the following left shift
    // carries correctly into the next decimal digit.
    function automatic logic [BW-1:0] add3(input logic [BW-1:0] a);
        logic [BW-1:0] res;
        res = a;
        for (int i = 0; i < DIGITS; i++) begin
            if (a[4*i +: 4] >= 4'd5) begin
                res[4*i +: 4] = a[4*i +: 4] + 4'd3;
            end
        end
        return res;
    endfunction

    always_comb begin
        accept     = (state == IDLE) && done && !error;
        accept_err = (state == IDLE) && done && error;
        // cnt counts completed shifts, so this edge performs shift SIZE.
        last_shift = (state == SHIFT) && (cnt == CW'(SIZE - 1));
        q_adj      = add3(q_acc);
        r_adj      = add3(r_acc);
        q_acc_next = {q_adj[BW-2:0], q_bin[SIZE-1]};
        r_acc_next = {r_adj[BW-2:0], r_bin[SIZE-1]};
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = SHIFT;
            SHIFT:   if (last_shift) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_bin   <= '0;
            r_bin   <= '0;
            q_acc   <= '0;
            r_acc   <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
            valid   <= 1'b0;
            err_out <= 1'b0;
            overrun <= 1'b0;
            q_bcd   <= '0;
            r_bcd   <= '0;
        end else begin
            // Any done seen mid-conversion (including the final shift edge)
            // is dropped and flagged.
            overrun <= (state == SHIFT) && done;
            if (accept) begin
                q_bin <= quotient;
                r_bin <= remainder;
                q_acc <= '0;
                r_acc <= '0;
                cnt   <= '0;
                busy  <= 1'b1;
                valid <= 1'b0;
            end else if (accept_err) begin
                valid   <= 1'b1;
                err_out <= 1'b1;
                q_bcd   <= '0;
                r_bcd   <= '0;
                busy    <= 1'b0;
            end else if (state == SHIFT) begin
                q_bin <= q_bin << 1;
                r_bin <= r_bin << 1;
                q_acc <= q_acc_next;
                r_acc <= r_acc_next;
                cnt   <= cnt + CW'(1);
                if (last_shift) begin
                    q_bcd   <= q_acc_next;
                    r_bcd   <= r_acc_next;
                    valid   <= 1'b1;
                    err_out <= 1'b0;
                    busy    <= 1'b0;
                end
            end
        end
    end

endmodule

// File: doc/div_result_bcd.md
DIV_RESULT_BCD -- requirements
Module: div_result_bcd

Interface
REQ-001 The block SHALL have parameter SIZE, default 32, giving the binary width of quotient and remainder.
REQ-002 The block SHALL have parameter DIGITS, default 10, giving the BCD digit count per result, with DIGITS >= ceil(SIZE*log10(2)).
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, rising-edge active.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port done, input, 1 bit: divider result-ready pulse, one cycle.
REQ-006 The block SHALL have port error, input, 1 bit: divider error flag, qualified by done.
REQ-007 The block SHALL have port quotient, input, SIZE bits: unsigned divider quotient, qualified by done.
REQ-008 The block SHALL have port remainder, input, SIZE bits: unsigned divider remainder, qualified by done.
REQ-009 The block SHALL have port busy, output, 1 bit: conversion in progress.
REQ-010 The block SHALL have port valid, output, 1 bit: q_bcd, r_bcd and err_out hold a completed result.
REQ-011 The block SHALL have port err_out, output, 1 bit: captured divider error for the current result.
REQ-012 The block SHALL have port overrun, output, 1 bit: one-cycle pulse when a done is dropped.
REQ-013 The block SHALL have port q_bcd, output, 4*DIGITS bits: packed BCD of quotient, most significant digit in the top nibble.
REQ-014 The block SHALL have port r_bcd, output, 4*DIGITS bits: packed BCD of remainder, same packing as q_bcd.

Function
REQ-015 The FSM SHALL have states IDLE, SHIFT and ERRHOLD; all outputs SHALL be registered.
REQ-016 In IDLE, the edge sampling done=1 with error=0 SHALL capture quotient and remainder into shift registers, clear the BCD accumulators and counter, and set busy=1, valid=0, state=SHIFT.
REQ-017 In IDLE, the edge sampling done=1 with error=1 SHALL set valid=1, err_out=1, q_bcd=0, r_bcd=0 and busy=0, and SHALL leave the FSM in IDLE (one-cycle latency, no SHIFT).
REQ-018 In SHIFT, each edge SHALL first add 3 to every accumulator nibble >= 5, then shift the accumulator left one bit, taking in the binary register MSB; both conversions SHALL run in lockstep.
REQ-019 The counter SHALL increment each SHIFT cycle; the edge performing shift SIZE SHALL load q_bcd and r_bcd, set valid=1, err_out=0, busy=0 and return to IDLE.
REQ-020 Latency SHALL be exactly SIZE cycles from busy rising to valid rising.
REQ-021 valid and the result outputs SHALL hold until the next accepted done, which clears valid on the capture edge (REQ-016) or replaces the result (REQ-017).
REQ-022 A done sampled while busy=1 SHALL be ignored, SHALL pulse overrun high for exactly one cycle, and SHALL NOT disturb the conversion in progress.
REQ-023 A done sampled on the same edge that completes a conversion SHALL be treated as an overrun (REQ-022).
REQ-024 A done sampled on the first cycle after valid rises SHALL be accepted normally (back-to-back operation).
REQ-025 A quotient or remainder of zero SHALL still take SIZE cycles and SHALL yield all-zero BCD.

Reset
REQ-026 Assertion of reset (reset=0) SHALL immediately force state=IDLE and clear busy, valid, err_out, overrun, q_bcd, r_bcd, the counter and all internal registers, including mid-conversion.
REQ-027 After reset deasserts, the first done SHALL be processed normally with no residue from an aborted conversion.

Verification
REQ-028 done with quotient=12345, remainder=67, error=0 -> busy high for 32 cycles, then valid=1, q_bcd=40'h0000012345, r_bcd=40'h0000000067, err_out=0.
REQ-029 done with quotient=32'hFFFFFFFF, remainder=0 -> after 32 cycles, q_bcd=40'h4294967295, r_bcd=0.
REQ-030 done with error=1 -> on the next cycle, valid=1, err_out=1, q_bcd=0, r_bcd=0, busy=0.
REQ-031 done pulsed 5 cycles into a conversion of 100 -> overrun high for 1 cycle, and the final q_bcd is 40'h0000000100.
REQ-032 reset pulled low 10 cycles into a conversion -> all outputs 0 at once; then done with quotient=9 -> q_bcd=40'h0000000009 after 32 cycles.
REQ-033 Two results with the second done one cycle after valid rises -> second accepted, valid drops for 32 cycles, both results correct.
